controlador_caida_cubo: RTL and testbench

Drives the falling motion of the currently enabled cube in the Canasta game and decides whether the basket caught or missed it. Sits directly upstream of the one-hot next-cube register: it consumes that register's `cubos` vector as `cubo_activo` and produces the single-cycle `pulso_siguiente` that advances it. Also tracks score and lives for the HUD and video stages.

---
 rtl/canasta_pkg.sv | 35 +++
 rtl/detector_colision_canasta.sv | 27 ++
 rtl/controlador_caida_cubo.sv | 158 +++++++++++++++
 tb/tb_controlador_caida_cubo.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/canasta_pkg.sv
// canasta_pkg: shared definitions for the Canasta game blocks.
//   - FSM state encoding for the cube-drop controller
//   - screen size (640x480), lane geometry, sprite widths
//   - coordinate width and the helper that maps the one-hot cube vector to a lane index
package canasta_pkg;

  localparam int ANCHO_COORD      = 10;
  localparam int PANTALLA_ANCHO   = 640;
  localparam int PANTALLA_ALTO    = 480;

  localparam int NUM_CARRILES     = 5;
  localparam int CARRIL_X0        = 56;
  localparam int CARRIL_PASO      = 128;
  localparam int CUBO_ANCHO_PX    = 16;
  localparam int CANASTA_ANCHO_PX = 64;

  typedef logic [ANCHO_COORD-1:0] coord_t;
  // One extra bit so edge sums never wrap.
  typedef logic [ANCHO_COORD:0]   coord_ext_t;

  localparam logic [2:0] ESPERA  = 3'd0;
  localparam logic [2:0] CAYENDO = 3'd1;
  localparam logic [2:0] EVALUA  = 3'd2;
  localparam logic [2:0] PAUSA   = 3'd3;
  localparam logic [2:0] FIN     = 3'd4;

  // Lowest set bit wins; an all-zero vector falls back to lane 0.
  function automatic logic [2:0] indice_carril(input logic [NUM_CARRILES-1:0] v);
    indice_carril = 3'd0;
    for (int i = NUM_CARRILES - 1; i >= 0; i--) begin
      if (v[i]) indice_carril = 3'(i);
    end
  endfunction

endpackage

// File: rtl/detector_colision_canasta.sv
// detector_colision_canasta: combinational horizontal-overlap test between the
// falling cube and the basket. Touching edges do not count as overlap.
// Ports:
//   cubo_x    in  10  cube left edge, px
//   canasta_x in  10  basket left edge, px
//   solapado  out 1   high when the two spans overlap
module detector_colision_canasta
  import canasta_pkg::*;
#(
  parameter int CUBO_ANCHO    = CUBO_ANCHO_PX,
  parameter int CANASTA_ANCHO = CANASTA_ANCHO_PX
) (
  input  logic [ANCHO_COORD-1:0] cubo_x,
  input  logic [ANCHO_COORD-1:0] canasta_x,
  output logic                   solapado
);

  coord_ext_t borde_der_cubo;
  coord_ext_t borde_der_canasta;

  assign borde_der_cubo    = coord_ext_t'(cubo_x) + coord_ext_t'(CUBO_ANCHO);
  assign borde_der_canasta = coord_ext_t'(canasta_x) + coord_ext_t'(CANASTA_ANCHO);

  assign solapado = (borde_der_cubo > coord_ext_t'(canasta_x)) &&
                    (coord_ext_t'(cubo_x) < borde_der_canasta);

endmodule

// File: rtl/controlador_caida_cubo.sv
// controlador_caida_cubo: moves the active cube down the screen one step per
// frame tick, decides catch/miss on landing, keeps score and lives, and pulses
// the next-cube register after a pause.
// Optional build macro: CANASTA_ACELERACION_EN -- fall speed grows with the
// score (VELOCIDAD + puntaje/8, capped at 8 px/tick); otherwise constant.
// Ports:
//   clk, reset (sync, active-high)
//   tick_frame      in  1   one pulse per video frame
//   iniciar         in  1   start/restart request, honoured in ESPERA/FIN
//   cubo_activo     in  5   one-hot cube index from the next-cube register
//   canasta_x       in  10  basket left edge
//   cubo_x/cubo_y   out 10  active cube position (x combinational from cubo_activo)
//   cubo_visible    out 1   high while falling
//   pulso_siguiente out 1   one-cycle advance to the next-cube register
//   atrapado/perdido out 1  one-cycle result pulses
//   puntaje         out 8   catches, saturating
//   vidas           out 2   remaining lives
//   fin_juego       out 1   game over
//
// state   | meaning
// ESPERA  | idle after reset, waiting for iniciar
// CAYENDO | cube visible, moving down on each frame tick
// EVALUA  | single cycle: landed, decide catch or miss
// PAUSA   | counting frame ticks before the next cube
// FIN     | no lives left, score held, waiting for iniciar
module controlador_caida_cubo
  import canasta_pkg::*;
#(
  parameter int Y_INICIO      = 0,
  parameter int Y_SUELO       = 440,
  parameter int VELOCIDAD     = 2,
  parameter int CUBO_ANCHO    = CUBO_ANCHO_PX,
  parameter int CANASTA_ANCHO = CANASTA_ANCHO_PX,
  parameter int LANE_X0       = CARRIL_X0,
  parameter int LANE_PASO     = CARRIL_PASO,
  parameter int PAUSA_TICKS   = 30,
  parameter int VIDAS_INI     = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    tick_frame,
  input  logic                    iniciar,
  input  logic [NUM_CARRILES-1:0] cubo_activo,
  input  logic [ANCHO_COORD-1:0]  canasta_x,
  output logic [ANCHO_COORD-1:0]  cubo_x,
  output logic [ANCHO_COORD-1:0]  cubo_y,
  output logic                    cubo_visible,
  output logic                    pulso_siguiente,
  output logic                    atrapado,
  output logic                    perdido,
  output logic [7:0]              puntaje,
  output logic [1:0]              vidas,
  output logic                    fin_juego
);

  localparam int ANCHO_CNT = (PAUSA_TICKS > 1) ? $clog2(PAUSA_TICKS + 1) : 1;

  logic [2:0]           estado;
  logic [ANCHO_CNT-1:0] cnt_pausa;
  logic [3:0]           vel;
  coord_ext_t           y_sig;
  logic                 solapado;

  always_comb begin
    cubo_x = coord_t'(LANE_X0 + int'(indice_carril(cubo_activo)) * LANE_PASO);
  end

`ifdef CANASTA_ACELERACION_EN
  logic [8:0] vel_suma;
  always_comb begin
    vel_suma = 9'(VELOCIDAD) + 9'(puntaje[7:3]);
    vel      = (vel_suma > 9'd8) ? 4'd8 : vel_suma[3:0];
  end
`else
  assign vel = 4'(VELOCIDAD);
`endif

  assign y_sig = coord_ext_t'(cubo_y) + coord_ext_t'(vel);

  detector_colision_canasta #(
    .CUBO_ANCHO    (CUBO_ANCHO),
    .CANASTA_ANCHO (CANASTA_ANCHO)
  ) u_detector (
    .cubo_x    (cubo_x),
    .canasta_x (canasta_x),
    .solapado  (solapado)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      estado          <= ESPERA;
      cubo_y          <= coord_t'(Y_INICIO);
      puntaje         <= 8'd0;
      vidas           <= 2'd0;
      cnt_pausa       <= '0;
      atrapado        <= 1'b0;
      perdido         <= 1'b0;
      pulso_siguiente <= 1'b0;
    end else begin
      atrapado        <= 1'b0;
      perdido         <= 1'b0;
      pulso_siguiente <= 1'b0;
      case (estado)
        ESPERA, FIN: begin
          if (iniciar) begin
            vidas   <= 2'(VIDAS_INI);
            puntaje <= 8'd0;
            cubo_y  <= coord_t'(Y_INICIO);
            estado  <= CAYENDO;
          end
        end
        CAYENDO: begin
          if (tick_frame) begin
            if (y_sig >= coord_ext_t'(Y_SUELO)) begin
              cubo_y <= coord_t'(Y_SUELO);
              estado <= EVALUA;
            end else begin
              cubo_y <= y_sig[ANCHO_COORD-1:0];
            end
          end
        end
        EVALUA: begin
          if (solapado) begin
            atrapado  <= 1'b1;
            if (puntaje != 8'hFF) puntaje <= puntaje + 8'd1;
            cnt_pausa <= '0;
            estado    <= PAUSA;
          end else begin
            perdido <= 1'b1;
            vidas   <= vidas - 2'd1;
            if (vidas == 2'd1) begin
              estado <= FIN;
            end else begin
              cnt_pausa <= '0;
              estado    <= PAUSA;
            end
          end
        end
        PAUSA: begin
          if (tick_frame) begin
            if (cnt_pausa == ANCHO_CNT'(PAUSA_TICKS - 1)) begin
              pulso_siguiente <= 1'b1;
              cubo_y          <= coord_t'(Y_INICIO);
              estado          <= CAYENDO;
            end else begin
              cnt_pausa <= cnt_pausa + 1'b1;
            end
          end
        end
        default: estado <= ESPERA;
      endcase
    end
  end

  assign cubo_visible = (estado == CAYENDO);
  assign fin_juego    = (estado == FIN);

endmodule

// File: tb/tb_controlador_caida_cubo.sv
module tb_controlador_caida_cubo;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick_frame;
  logic       iniciar;
  logic [4:0] cubo_activo;
  logic [9:0] canasta_x;
  logic [9:0] cubo_x;
  logic [9:0] cubo_y;
  logic       cubo_visible;
  logic       pulso_siguiente;
  logic       atrapado;
  logic       perdido;
  logic [7:0] puntaje;
  logic [1:0] vidas;
  logic       fin_juego;

  controlador_caida_cubo dut (
    .clk             (clk),
    .reset           (reset),
    .tick_frame      (tick_frame),
    .iniciar         (iniciar),
    .cubo_activo     (cubo_activo),
    .canasta_x       (canasta_x),
    .cubo_x          (cubo_x),
    .cubo_y          (cubo_y),
    .cubo_visible    (cubo_visible),
    .pulso_siguiente (pulso_siguiente),
    .atrapado        (atrapado),
    .perdido         (perdido),
    .puntaje         (puntaje),
    .vidas           (vidas),
    .fin_juego       (fin_juego)
  );

  always #5 clk = ~clk;

  int errores = 0;
  int checks  = 0;

  task automatic chk(input string nom, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errores++;
      $display("FAIL %s: got %0d expected %0d", nom, act, req);
    end
  endtask

  // One clock cycle with tick_frame at the given level; returns 1 time unit after the edge.
  task automatic ciclo(input logic t);
    tick_frame = t;
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    ciclo(1'b1);
    ciclo(1'b0);
  endtask

  typedef struct {
    logic [4:0] activo;
    logic [9:0] canasta;
    int         x_esp;
    bit         atrapa;
    bit         tick_evalua;
  } vector_t;

  typedef struct {
    bit atrapa;
    int puntaje;
    int vidas;
  } resultado_t;

  vector_t    tabla[10];
  resultado_t sb[$];
  resultado_t r;
  int         n_pulsos = 0;
  logic       pulso_prev = 1'b0;

  // Result scoreboard and next-cube pulse monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (atrapado || perdido) begin
      if (sb.size() == 0) begin
        chk("pulso_resultado_inesperado", {30'd0, atrapado, perdido}, 32'd0);
      end else begin
        r = sb.pop_front();
        chk("atrapado", atrapado, r.atrapa);
        chk("perdido", perdido, !r.atrapa);
        chk("puntaje_tras_resultado", puntaje, r.puntaje);
        chk("vidas_tras_resultado", vidas, r.vidas);
      end
    end
    if (pulso_siguiente) begin
      n_pulsos++;
      chk("ancho_pulso_siguiente", pulso_prev, 0);
    end
    pulso_prev = pulso_siguiente;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $display("Result: errors=%0d of %0d checks", errores + 1, checks + 1);
    $fatal(1);
  end

  int exp_p;
  int exp_v;
  int p0;

  initial begin
    //            activo    canasta x_esp atrapa tick_evalua
    tabla[0] = '{5'b00100, 10'd300, 312, 1'b1, 1'b1};
    tabla[1] = '{5'b10000, 10'd0,   568, 1'b0, 1'b0};
    tabla[2] = '{5'b00100, 10'd327, 312, 1'b1, 1'b1};
    tabla[3] = '{5'b00000, 10'd40,  56,  1'b1, 1'b0};
    tabla[4] = '{5'b01010, 10'd184, 184, 1'b1, 1'b1};
    tabla[5] = '{5'b00100, 10'd328, 312, 1'b0, 1'b0};
    tabla[6] = '{5'b00010, 10'd500, 184, 1'b0, 1'b1};
    tabla[7] = '{5'b10000, 10'd0,   568, 1'b0, 1'b0};
    tabla[8] = '{5'b00001, 10'd600, 56,  1'b0, 1'b1};
    tabla[9] = '{5'b01000, 10'd100, 440, 1'b0, 1'b0};

    reset       = 1'b1;
    tick_frame  = 1'b0;
    iniciar     = 1'b0;
    cubo_activo = 5'b00001;
    canasta_x   = 10'd0;
    repeat (3) ciclo(1'b0);
    chk("rst_cubo_y", cubo_y, 0);
    chk("rst_puntaje", puntaje, 0);
    chk("rst_vidas", vidas, 0);
    chk("rst_visible", cubo_visible, 0);
    chk("rst_fin", fin_juego, 0);
    chk("rst_pulsos", {atrapado, perdido, pulso_siguiente}, 0);

    reset = 1'b0;
    tick();
    chk("espera_sin_iniciar", cubo_visible, 0);

    iniciar = 1'b1;
    ciclo(1'b0);
    iniciar = 1'b0;
    exp_p = 0;
    exp_v = 3;
    chk("inicio_vidas", vidas, 3);
    chk("inicio_puntaje", puntaje, 0);
    chk("inicio_visible", cubo_visible, 1);

    for (int i = 0; i < 10; i++) begin
      cubo_activo = tabla[i].activo;
      canasta_x   = tabla[i].canasta;
      #1;
      chk($sformatf("v%0d_cubo_x", i), cubo_x, tabla[i].x_esp);
      chk($sformatf("v%0d_y_inicio", i), cubo_y, 0);
      for (int k = 1; k <= 219; k++) begin
        if (i == 1 && k == 100) iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
      end
      chk($sformatf("v%0d_y_438", i), cubo_y, 438);
      chk($sformatf("v%0d_visible_cayendo", i), cubo_visible, 1);
      chk($sformatf("v%0d_vidas_cayendo", i), vidas, exp_v);

      if (tabla[i].atrapa) begin
        if (exp_p < 255) exp_p++;
      end else begin
        exp_v--;
      end
      sb.push_back('{tabla[i].atrapa, exp_p, exp_v});

      ciclo(1'b1);
      chk($sformatf("v%0d_y_suelo", i), cubo_y, 440);
      chk($sformatf("v%0d_oculto_evalua", i), cubo_visible, 0);
      ciclo(tabla[i].tick_evalua);
      ciclo(1'b0);
      chk($sformatf("v%0d_resultado_emitido", i), sb.size(), 0);

      if (exp_v == 0) begin
        chk($sformatf("v%0d_fin_juego", i), fin_juego, 1);
        p0 = n_pulsos;
        repeat (40) tick();
        chk($sformatf("v%0d_fin_sin_pulso", i), n_pulsos, p0);
        chk($sformatf("v%0d_fin_mantiene", i), fin_juego, 1);
        chk($sformatf("v%0d_fin_puntaje", i), puntaje, exp_p);
        iniciar = 1'b1;
        ciclo(1'b0);
        iniciar = 1'b0;
        exp_v = 3;
        exp_p = 0;
        chk($sformatf("v%0d_reinicio_vidas", i), vidas, 3);
        chk($sformatf("v%0d_reinicio_puntaje", i), puntaje, 0);
        chk($sformatf("v%0d_reinicio_fin", i), fin_juego, 0);
        chk($sformatf("v%0d_reinicio_visible", i), cubo_visible, 1);
        chk($sformatf("v%0d_reinicio_y", i), cubo_y, 0);
      end else begin
        chk($sformatf("v%0d_no_fin", i), fin_juego, 0);
        p0 = n_pulsos;
        repeat (29) tick();
        chk($sformatf("v%0d_pausa_sin_pulso", i), n_pulsos, p0);
        chk($sformatf("v%0d_pausa_oculto", i), cubo_visible, 0);
        chk($sformatf("v%0d_pausa_y", i), cubo_y, 440);
        ciclo(1'b1);
        chk($sformatf("v%0d_pulso_siguiente", i), pulso_siguiente, 1);
        chk($sformatf("v%0d_visible_tras_pausa", i), cubo_visible, 1);
        chk($sformatf("v%0d_y_tras_pausa", i), cubo_y, 0);
        ciclo(1'b0);
        chk($sformatf("v%0d_pulso_baja", i), pulso_siguiente, 0);
        chk($sformatf("v%0d_un_pulso", i), n_pulsos, p0 + 1);
      end
    end

    // Reset in the middle of a pause: everything back to idle, no pulse afterwards.
    cubo_activo = 5'b00100;
    canasta_x   = 10'd300;
    exp_p       = 1;
    sb.push_back('{1'b1, exp_p, exp_v});
    repeat (220) tick();
    ciclo(1'b0);
    ciclo(1'b0);
    chk("rp_resultado_emitido", sb.size(), 0);
    repeat (10) tick();
    p0 = n_pulsos;
    reset = 1'b1;
    ciclo(1'b0);
    reset = 1'b0;
    chk("rp_cubo_y", cubo_y, 0);
    chk("rp_puntaje", puntaje, 0);
    chk("rp_vidas", vidas, 0);
    chk("rp_visible", cubo_visible, 0);
    chk("rp_fin", fin_juego, 0);
    chk("rp_pulsos", {atrapado, perdido, pulso_siguiente}, 0);
    repeat (40) tick();
    chk("rp_sin_pulso", n_pulsos, p0);
    chk("rp_sigue_espera", cubo_visible, 0);
    chk("rp_y_quieto", cubo_y, 0);

    $display("Result: errors=%0d of %0d checks", errores, checks);
    $finish;
  end

endmodule
